// File: rtl/wb_arb_2m4s_pkg.sv
// Shared definitions for the 2-master / 4-slave Wishbone arbiter:
// slave indices, address decode field and arbiter FSM encoding.
package wb_arb_2m4s_pkg;

    localparam int NUM_SLV = 4;
    localparam int DEC_HI  = 31;
    localparam int DEC_LO  = 28;

    localparam logic [1:0] SLV_DRAM  = 2'd0;
    localparam logic [1:0] SLV_IRAM  = 2'd1;
    localparam logic [1:0] SLV_GPIO  = 2'd2;
    localparam logic [1:0] SLV_SPARE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    function automatic logic [NUM_SLV-1:0] slv_onehot(input logic [1:0] idx);
        logic [NUM_SLV-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Bus watchdog: counts consecutive stalled strobe cycles and flags a timeout
// on the stalled cycle that brings the count to TIMEOUT_CYC.
module wb_arb_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic en_i,
    input  logic ack_i,
    output logic timeout_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic             stall;

    assign stall     = en_i & ~ack_i;
    // An ack in the would-be timeout cycle suppresses the timeout.
    assign timeout_o = stall && (count_q == LAST_CNT);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        count_d = '0;
        if (stall && !timeout_o)
            count_d = count_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            count_q <= '0;
        else
            count_q <= count_d;
    end

endmodule

// File: rtl/wb_arb_2m4s.sv
// Round-robin Wishbone arbiter for two masters onto one shared bus, with
// addr[31:28] slave decode, decode-error and watchdog error termination.
module wb_arb_2m4s
    import wb_arb_2m4s_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC   = 255,
    parameter int unsigned CNT_W         = 8,
    parameter bit          RR_RESET_LAST = 1'b1
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         m0_cyc_i,
    input  logic         m0_stb_i,
    input  logic         m0_we_i,
    input  logic [31:0]  m0_addr_i,
    input  logic [31:0]  m0_data_i,
    input  logic [3:0]   m0_sel_i,
    output logic [31:0]  m0_data_o,
    output logic         m0_ack_o,
    output logic         m0_err_o,
    input  logic         m1_cyc_i,
    input  logic         m1_stb_i,
    input  logic         m1_we_i,
    input  logic [31:0]  m1_addr_i,
    input  logic [31:0]  m1_data_i,
    input  logic [3:0]   m1_sel_i,
    output logic [31:0]  m1_data_o,
    output logic         m1_ack_o,
    output logic         m1_err_o,
    output logic [3:0]   s_cyc_o,
    output logic [3:0]   s_stb_o,
    output logic         s_we_o,
    output logic [31:0]  s_addr_o,
    output logic [31:0]  s_data_o,
    output logic [3:0]   s_sel_o,
    input  logic [31:0]  s0_data_i,
    input  logic [31:0]  s1_data_i,
    input  logic [31:0]  s2_data_i,
    input  logic [31:0]  s3_data_i,
    input  logic [3:0]   s_ack_i,
    output logic [1:0]   gnt_o
);

    state_e       state_q, state_d;
    logic         owner_q, owner_d;
    logic         last_q, last_d;
    logic [1:0]   gnt_q, gnt_d;

    logic         req0, req1;
    logic         own_cyc, own_stb, own_we;
    logic [31:0]  own_addr, own_wdata;
    logic [3:0]   own_sel;
    logic         owning, dec_ok;
    logic [1:0]   slv_idx;
    logic [3:0]   slv_sel;
    logic [31:0]  slv_rdata;
    logic         slv_ack;
    logic         wd_en, wd_timeout;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;

    always_comb begin
        if (owner_q) begin
            own_cyc   = m1_cyc_i;
            own_stb   = m1_stb_i;
            own_we    = m1_we_i;
            own_addr  = m1_addr_i;
            own_wdata = m1_data_i;
            own_sel   = m1_sel_i;
        end else begin
            own_cyc   = m0_cyc_i;
            own_stb   = m0_stb_i;
            own_we    = m0_we_i;
            own_addr  = m0_addr_i;
            own_wdata = m0_data_i;
            own_sel   = m0_sel_i;
        end
    end

    assign owning  = (state_q == ST_OWN0) || (state_q == ST_OWN1);
    assign dec_ok  = own_addr[DEC_HI:DEC_LO] < 4'(NUM_SLV);
    assign slv_idx = own_addr[DEC_LO+1:DEC_LO];
    assign slv_sel = (owning && dec_ok) ? slv_onehot(slv_idx) : '0;

    // Shared bus is quiet (all zero) whenever nobody owns it, including ERR.
    assign s_cyc_o  = slv_sel & {NUM_SLV{own_cyc}};
    assign s_stb_o  = slv_sel & {NUM_SLV{own_stb}};
    assign s_we_o   = owning & own_we;
    assign s_addr_o = owning ? own_addr  : '0;
    assign s_data_o = owning ? own_wdata : '0;
    assign s_sel_o  = owning ? own_sel   : '0;

    always_comb begin
        case (slv_idx)
            SLV_DRAM:  slv_rdata = s0_data_i;
            SLV_IRAM:  slv_rdata = s1_data_i;
            SLV_GPIO:  slv_rdata = s2_data_i;
            SLV_SPARE: slv_rdata = s3_data_i;
            default:   slv_rdata = '0;
        endcase
    end

    // Acks from slaves other than the decoded one are masked by slv_sel.
    assign slv_ack   = (|(s_ack_i & slv_sel)) & own_stb & own_cyc;

    assign m0_ack_o  = slv_ack & ~owner_q;
    assign m1_ack_o  = slv_ack &  owner_q;
    assign m0_data_o = (owning && dec_ok && !owner_q) ? slv_rdata : '0;
    assign m1_data_o = (owning && dec_ok &&  owner_q) ? slv_rdata : '0;
    assign m0_err_o  = (state_q == ST_ERR) & ~owner_q;
    assign m1_err_o  = (state_q == ST_ERR) &  owner_q;
    assign gnt_o     = gnt_q;

    assign wd_en = owning & dec_ok & own_cyc & own_stb;

    wb_arb_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) u_watchdog (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .en_i      (wd_en),
        .ack_i     (slv_ack),
        .timeout_o (wd_timeout)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                // On a tie the master that was not granted last wins.
                if (req0 && (!req1 || last_q)) begin
                    state_d = ST_OWN0;
                    owner_d = 1'b0;
                end else if (req1) begin
                    state_d = ST_OWN1;
                    owner_d = 1'b1;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (!own_cyc) begin
                    state_d = ST_IDLE;
                    last_d  = owner_q;
                end else if ((own_stb && !dec_ok) || wd_timeout) begin
                    state_d = ST_ERR;
                end
            end
            ST_ERR: begin
                if (own_cyc) begin
                    state_d = owner_q ? ST_OWN1 : ST_OWN0;
                end else begin
                    state_d = ST_IDLE;
                    last_d  = owner_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_OWN0: gnt_d = 2'b01;
            ST_OWN1: gnt_d = 2'b10;
            ST_ERR:  gnt_d = owner_d ? 2'b10 : 2'b01;
            default: gnt_d = 2'b00;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            last_q  <= RR_RESET_LAST;
            gnt_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
        end
    end

endmodule

// File: tb/tb_wb_arb_2m4s.sv
// Directed bench for wb_arb_2m4s: stimulus pushes expected master terminations
// into a queue, a negedge monitor pops and compares each ack/err it observes.
module tb_wb_arb_2m4s;

    typedef struct packed {
        logic        mst;
        logic        err;
        logic [31:0] data;
    } evt_t;

    logic        clk_i  = 1'b0;
    logic        rstn_i = 1'b0;
    logic        m0_cyc_i = 1'b0, m0_stb_i = 1'b0, m0_we_i = 1'b0;
    logic [31:0] m0_addr_i = '0, m0_data_i = '0;
    logic [3:0]  m0_sel_i = '0;
    logic [31:0] m0_data_o;
    logic        m0_ack_o, m0_err_o;
    logic        m1_cyc_i = 1'b0, m1_stb_i = 1'b0, m1_we_i = 1'b0;
    logic [31:0] m1_addr_i = '0, m1_data_i = '0;
    logic [3:0]  m1_sel_i = '0;
    logic [31:0] m1_data_o;
    logic        m1_ack_o, m1_err_o;
    logic [3:0]  s_cyc_o, s_stb_o;
    logic        s_we_o;
    logic [31:0] s_addr_o, s_data_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s0_data_i = 32'hDEAD_BEEF;
    logic [31:0] s1_data_i = 32'h1111_1111;
    logic [31:0] s2_data_i = 32'h2222_2222;
    logic [31:0] s3_data_i = 32'h3333_3333;
    logic [3:0]  s_ack_i = '0;
    logic [1:0]  gnt_o;

    evt_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk_i = ~clk_i;

    wb_arb_2m4s #(
        .TIMEOUT_CYC   (4),
        .CNT_W         (8),
        .RR_RESET_LAST (1'b1)
    ) dut (
        .clk_i     (clk_i),     .rstn_i    (rstn_i),
        .m0_cyc_i  (m0_cyc_i),  .m0_stb_i  (m0_stb_i),  .m0_we_i  (m0_we_i),
        .m0_addr_i (m0_addr_i), .m0_data_i (m0_data_i), .m0_sel_i (m0_sel_i),
        .m0_data_o (m0_data_o), .m0_ack_o  (m0_ack_o),  .m0_err_o (m0_err_o),
        .m1_cyc_i  (m1_cyc_i),  .m1_stb_i  (m1_stb_i),  .m1_we_i  (m1_we_i),
        .m1_addr_i (m1_addr_i), .m1_data_i (m1_data_i), .m1_sel_i (m1_sel_i),
        .m1_data_o (m1_data_o), .m1_ack_o  (m1_ack_o),  .m1_err_o (m1_err_o),
        .s_cyc_o   (s_cyc_o),   .s_stb_o   (s_stb_o),   .s_we_o   (s_we_o),
        .s_addr_o  (s_addr_o),  .s_data_o  (s_data_o),  .s_sel_o  (s_sel_o),
        .s0_data_i (s0_data_i), .s1_data_i (s1_data_i),
        .s2_data_i (s2_data_i), .s3_data_i (s3_data_i),
        .s_ack_i   (s_ack_i),   .gnt_o     (gnt_o)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_m(input int m, input logic cyc, input logic stb, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata);
        if (m == 0) begin
            m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we;
            m0_addr_i = addr; m0_data_i = wdata; m0_sel_i = 4'hF;
        end else begin
            m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we;
            m1_addr_i = addr; m1_data_i = wdata; m1_sel_i = 4'hF;
        end
    endtask

    task automatic expect_evt(input logic mst, input logic err, input logic [31:0] data);
        evt_t e;
        e.mst  = mst;
        e.err  = err;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input logic mst, input logic err, input logic [31:0] data);
        evt_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL evt_unexpected got m%0d err=%0b data=%0h exp none at %0t",
                     mst, err, data, $time);
        end else begin
            e = exp_q.pop_front();
            check("evt", {mst, err, data}, {e.mst, e.err, e.data});
        end
    endtask

    always @(negedge clk_i) begin
        if (rstn_i) begin
            if (m0_ack_o || m0_err_o) pop_cmp(1'b0, m0_err_o, m0_data_o);
            if (m1_ack_o || m1_err_o) pop_cmp(1'b1, m1_err_o, m1_data_o);
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "bench did not finish");
    end

    initial begin
        // Reset values
        #2;
        check("rst_ctl", {gnt_o, s_cyc_o, s_stb_o, s_we_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, 0);
        check("rst_bus", {s_addr_o, s_data_o}, 0);
        check("rst_rd", {m0_data_o, m1_data_o}, 0);
        check("rst_sel", s_sel_o, 0);
        tick();
        rstn_i = 1'b1;
        tick();

        // 1: m0 read of slave 0, ack two cycles after strobe
        drive_m(0, 1, 1, 0, 32'h0000_0010, 0);
        #1 check("t1_gnt_idle", gnt_o, 2'b00);
        tick();
        check("t1_gnt", gnt_o, 2'b01);
        check("t1_stb", s_stb_o, 4'b0001);
        check("t1_cyc", s_cyc_o, 4'b0001);
        check("t1_addr", s_addr_o, 32'h0000_0010);
        tick();
        tick();
        expect_evt(0, 0, 32'hDEAD_BEEF);
        s_ack_i = 4'b0001;
        tick();
        s_ack_i = 4'b0000;
        drive_m(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        check("t1_release", gnt_o, 2'b00);

        // 2: tie from reset -> m0, then m1, then alternate back to m0
        rstn_i = 1'b0;
        tick();
        rstn_i = 1'b1;
        drive_m(0, 1, 1, 0, 32'h0000_0020, 0);
        drive_m(1, 1, 1, 0, 32'h1000_0000, 0);
        tick();
        check("t2_gnt_m0", gnt_o, 2'b01);
        expect_evt(0, 0, 32'hDEAD_BEEF);
        s_ack_i = 4'b0001;
        tick();
        s_ack_i = 4'b0000;
        drive_m(0, 0, 0, 0, 0, 0);
        check("t2_hold", gnt_o, 2'b01);
        tick();
        check("t2_no_handover", gnt_o, 2'b00);
        tick();
        check("t2_gnt_m1", gnt_o, 2'b10);
        check("t2_stb_m1", s_stb_o, 4'b0010);
        expect_evt(1, 0, 32'h1111_1111);
        s_ack_i = 4'b0010;
        tick();
        s_ack_i = 4'b0000;
        drive_m(1, 0, 0, 0, 0, 0);
        tick();
        drive_m(0, 1, 1, 0, 32'h0000_0024, 0);
        drive_m(1, 1, 1, 0, 32'h1000_0004, 0);
        tick();
        check("t2_alt_m0", gnt_o, 2'b01);
        expect_evt(0, 0, 32'hDEAD_BEEF);
        s_ack_i = 4'b0001;
        tick();
        s_ack_i = 4'b0000;
        drive_m(0, 0, 0, 0, 0, 0);
        drive_m(1, 0, 0, 0, 0, 0);
        tick();
        tick();
        check("t2_idle", gnt_o, 2'b00);

        // 3: m1 locks the bus over three back-to-back strobes while m0 waits
        drive_m(0, 1, 1, 0, 32'h0000_0030, 0);
        drive_m(1, 1, 1, 0, 32'h1000_0008, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("t3_lock", gnt_o, 2'b10);
            s1_data_i = 32'hA5A5_0000 + 32'(i);
            expect_evt(1, 0, 32'hA5A5_0000 + 32'(i));
            s_ack_i = 4'b0010;
            tick();
        end
        s_ack_i = 4'b0000;
        drive_m(1, 0, 0, 0, 0, 0);
        check("t3_still_m1", gnt_o, 2'b10);
        tick();
        check("t3_idle_gap", gnt_o, 2'b00);
        tick();
        check("t3_gnt_m0", gnt_o, 2'b01);
        check("t3_stb_m0", s_stb_o, 4'b0001);
        expect_evt(0, 0, 32'hDEAD_BEEF);
        s_ack_i = 4'b0001;
        tick();
        s_ack_i = 4'b0000;
        drive_m(0, 0, 0, 0, 0, 0);
        tick();
        tick();

        // 4: write to unmapped 0x5000_0000 -> decode error, no strobe
        drive_m(0, 1, 1, 1, 32'h5000_0000, 32'h1234_5678);
        tick();
        check("t4_gnt", gnt_o, 2'b01);
        check("t4_no_stb", {s_cyc_o, s_stb_o}, 8'h00);
        check("t4_no_err_yet", m0_err_o, 1'b0);
        expect_evt(0, 1, 32'h0);
        tick();
        check("t4_err", m0_err_o, 1'b1);
        check("t4_err_stb", s_stb_o, 4'b0000);
        drive_m(0, 0, 0, 0, 0, 0);
        tick();
        check("t4_err_once", {m0_err_o, gnt_o}, 3'b000);

        // 5: slave 3 never acks -> watchdog error, then count restarts
        drive_m(0, 1, 1, 0, 32'h3000_0000, 0);
        tick();
        check("t5_gnt", gnt_o, 2'b01);
        check("t5_stb1", s_stb_o, 4'b1000);
        tick();
        check("t5_stb2", s_stb_o, 4'b1000);
        s_ack_i = 4'b0001;
        #1 check("t5_unsel_ack", m0_ack_o, 1'b0);
        tick();
        s_ack_i = 4'b0000;
        check("t5_stb3", s_stb_o, 4'b1000);
        tick();
        check("t5_stb4", {s_stb_o, m0_err_o}, 5'b1000_0);
        expect_evt(0, 1, 32'h0);
        tick();
        check("t5_to_bus", {s_cyc_o, s_stb_o}, 8'h00);
        check("t5_to_err", m0_err_o, 1'b1);
        drive_m(0, 1, 0, 0, 32'h3000_0000, 0);
        tick();
        check("t5_reown", {gnt_o, m0_err_o}, 3'b01_0);
        drive_m(0, 1, 1, 0, 32'h3000_0004, 0);
        tick();
        tick();
        tick();
        check("t5_restall", s_stb_o, 4'b1000);
        expect_evt(0, 0, 32'h3333_3333);
        s_ack_i = 4'b1000;
        tick();
        s_ack_i = 4'b0000;
        drive_m(0, 0, 0, 0, 0, 0);
        tick();
        tick();

        // 6: asynchronous reset mid-transfer, then first tie goes to m0
        drive_m(0, 1, 1, 1, 32'h0000_0040, 32'hCAFE_0001);
        tick();
        check("t6_gnt", gnt_o, 2'b01);
        check("t6_wr", {s_we_o, s_stb_o, s_data_o}, {1'b1, 4'b0001, 32'hCAFE_0001});
        rstn_i  = 1'b0;
        s_ack_i = 4'b0001;
        #1;
        check("t6_async_ctl", {gnt_o, s_cyc_o, s_stb_o, s_we_o, m0_ack_o, m0_err_o}, 0);
        check("t6_async_bus", {s_addr_o, s_data_o}, 0);
        check("t6_async_rd", {m0_data_o, s_sel_o}, 0);
        s_ack_i = 4'b0000;
        drive_m(1, 1, 1, 0, 32'h1000_0000, 0);
        tick();
        check("t6_held", gnt_o, 2'b00);
        rstn_i = 1'b1;
        tick();
        check("t6_tie_m0", gnt_o, 2'b01);
        expect_evt(0, 0, 32'hDEAD_BEEF);
        s_ack_i = 4'b0001;
        tick();
        s_ack_i = 4'b0000;
        drive_m(0, 0, 0, 0, 0, 0);
        drive_m(1, 0, 0, 0, 0, 0);
        tick();
        tick();
        tick();

        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
